// File: rtl/input_buffer_loader_pkg.sv
// Shared widths and load-stage FSM encoding for the input buffer loader and reader stages.
package input_buffer_loader_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned ADDR_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } load_state_t;

endpackage

// File: rtl/input_buffer_loader_load_addr_counter.sv
// Frame base latch plus wrapping word offset; produces the next buffer write address.
module load_addr_counter #(
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic [AW-1:0] base_in,
  input  logic          inc,
  output logic [AW-1:0] addr_c,
  output logic [AW:0]   cnt
);

  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] base_q, base_d;
  logic [AW:0]   cnt_q, cnt_d;

  always_comb begin
    base_d = base_q;
    cnt_d  = cnt_q;
    if (clear) begin
      base_d = base_in;
      cnt_d  = '0;
    end else if (inc) begin
      cnt_d = CW'(cnt_q + CW'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      cnt_q  <= '0;
    end else begin
      base_q <= base_d;
      cnt_q  <= cnt_d;
    end
  end

  // Address arithmetic is modulo the buffer depth, so frames may wrap past the top.
  assign addr_c = AW'(base_q + cnt_q[AW-1:0]);
  assign cnt    = cnt_q;

endmodule

// File: rtl/input_buffer_loader.sv
// Loads one frame from a valid/ready stream into consecutive input_buffer addresses.
module input_buffer_loader
  import input_buffer_loader_pkg::*;
#(
  parameter int unsigned LD_DATA_WIDTH = DATA_WIDTH,
  parameter int unsigned LD_ADDR_WIDTH = ADDR_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [LD_ADDR_WIDTH-1:0] base_addr,
  input  logic [LD_ADDR_WIDTH:0]   frame_len,
  input  logic                     s_valid,
  input  logic [LD_DATA_WIDTH-1:0] s_data,
  output logic                     s_ready,
  output logic                     wr_en,
  output logic [LD_ADDR_WIDTH-1:0] wr_addr,
  output logic [LD_DATA_WIDTH-1:0] wr_data,
  output logic                     busy,
  output logic                     done,
  output logic                     len_err,
  output logic [LD_ADDR_WIDTH:0]   word_cnt
);

  localparam int unsigned LW = LD_ADDR_WIDTH + 1;
  localparam logic [LD_ADDR_WIDTH:0] DEPTH = LW'(1) << LD_ADDR_WIDTH;

  load_state_t state_q, state_d;
  logic [LD_ADDR_WIDTH:0]   len_q, len_d;
  logic                     len_err_q, len_err_d;
  logic                     wr_en_q, wr_en_d;
  logic [LD_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [LD_DATA_WIDTH-1:0] wr_data_q, wr_data_d;

  logic                     accept_start;
  logic                     accept_word;
  logic                     last_word;
  logic [LD_ADDR_WIDTH-1:0] next_addr;
  logic [LD_ADDR_WIDTH:0]   cnt;

  assign s_ready      = (state_q == LOAD) && !abort;
  assign accept_word  = s_ready && s_valid;
  assign accept_start = (state_q == IDLE) && start && !abort;
  assign last_word    = accept_word && (LW'(cnt + LW'(1)) == len_q);

  load_addr_counter #(
    .AW(LD_ADDR_WIDTH)
  ) u_addr_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (accept_start),
    .base_in(base_addr),
    .inc    (accept_word),
    .addr_c (next_addr),
    .cnt    (cnt)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    len_err_d = len_err_q;
    wr_en_d   = accept_word;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    case (state_q)
      IDLE: begin
        if (accept_start) begin
          // Oversized requests are clamped to the buffer depth and flagged stickily.
          if (frame_len > DEPTH) begin
            len_d     = DEPTH;
            len_err_d = 1'b1;
          end else begin
            len_d = frame_len;
          end
          state_d = (frame_len == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (last_word) begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept_word) begin
      wr_addr_d = next_addr;
      wr_data_d = s_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      len_err_q <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      len_err_q <= len_err_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign len_err  = len_err_q;
  assign busy     = (state_q == LOAD);
  assign done     = (state_q == DONE);
  assign word_cnt = cnt;

endmodule

// File: tb/tb_input_buffer_loader.sv
// Randomized and directed bench for input_buffer_loader against a frame-level model.
module tb_input_buffer_loader;
  import input_buffer_loader_pkg::*;

  localparam int AW    = ADDR_WIDTH;
  localparam int DW    = DATA_WIDTH;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [AW-1:0] base_addr;
  logic [AW:0]   frame_len;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;
  logic          len_err;
  logic [AW:0]   word_cnt;

  input_buffer_loader #(
    .LD_DATA_WIDTH(DW),
    .LD_ADDR_WIDTH(AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .base_addr(base_addr),
    .frame_len(frame_len),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .len_err  (len_err),
    .word_cnt (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Frame-level model: is a frame being accepted, how far along, and what was written.
  bit m_load, m_done, m_err, m_we;
  int m_base, m_len, m_cnt, m_wa, m_wd;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_load = 0; m_done = 0; m_err = 0; m_we = 0;
        m_base = 0; m_len = 0; m_cnt = 0; m_wa = 0; m_wd = 0;
      end else begin
        bit nl, nd, we;
        nl = m_load; nd = 0; we = 0;
        if (m_load) begin
          if (abort) nl = 0;
          else if (s_valid) begin
            we   = 1;
            m_wa = (m_base + m_cnt) % DEPTH;
            m_wd = int'(s_data);
            m_cnt++;
            if (m_cnt == m_len) begin nl = 0; nd = 1; end
          end
        end else if (!m_done && start && !abort) begin
          m_cnt  = 0;
          m_base = int'(base_addr);
          if (int'(frame_len) > DEPTH) m_err = 1;
          m_len = (int'(frame_len) > DEPTH) ? DEPTH : int'(frame_len);
          if (m_len == 0) nd = 1; else nl = 1;
        end
        m_load = nl; m_done = nd; m_we = we;
      end
    end
  end

  int log_addr[$];
  int log_data[$];
  int n_done, done_w;

  // Per-cycle comparison against the model plus a write log for directed checks.
  initial begin
    forever begin
      @(negedge clk);
      chk("s_ready", int'(s_ready), int'(m_load && !abort));
      chk("busy", int'(busy), int'(m_load));
      chk("done", int'(done), int'(m_done));
      chk("len_err", int'(len_err), int'(m_err));
      chk("word_cnt", int'(word_cnt), m_cnt);
      chk("wr_en", int'(wr_en), int'(m_we));
      if (m_we) begin
        chk("wr_addr", int'(wr_addr), m_wa);
        chk("wr_data", int'(wr_data), m_wd);
      end
      if (wr_en) begin
        log_addr.push_back(int'(wr_addr));
        log_data.push_back(int'(wr_data));
      end
      if (done) begin
        n_done++;
        if (wr_en) done_w++;
      end
    end
  end

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    n_done = 0;
    done_w = 0;
  endtask

  task automatic step(input bit st, input bit ab, input bit v, input int d,
                      input int b, input int l);
    start     = st;
    abort     = ab;
    s_valid   = v;
    s_data    = DW'(d);
    base_addr = AW'(b);
    frame_len = (AW+1)'(l);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 0;
    start = 0; abort = 0; s_valid = 0; s_data = '0; base_addr = '0; frame_len = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    idle(2);

    // Reset in the middle of a frame after three words
    step(1, 0, 0, 0, 5, 8);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 16 + i, 0, 0);
    chk("pre_rst_busy", int'(busy), 1);
    chk("pre_rst_cnt", int'(word_cnt), 3);
    rst_n = 0;
    #1;
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_s_ready", int'(s_ready), 0);
    chk("rst_cnt", int'(word_cnt), 0);
    chk("rst_addr", int'(wr_addr), 0);
    chk("rst_data", int'(wr_data), 0);
    @(posedge clk);
    #1 rst_n = 1;
    idle(1);

    // Base 0, four words 0xA..0xD streamed back to back
    clear_log();
    step(1, 0, 0, 0, 0, 4);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 10 + i, 0, 0);
    idle(2);
    chk("s2_writes", log_addr.size(), 4);
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      chk("s2_addr", log_addr[i], i);
      chk("s2_data", log_data[i], 10 + i);
    end
    chk("s2_done", n_done, 1);
    chk("s2_done_w", done_w, 1);
    chk("s2_cnt", int'(word_cnt), 4);

    // Address wrap from the top of the buffer
    clear_log();
    step(1, 0, 0, 0, DEPTH - 2, 4);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 32 + i, 0, 0);
    idle(1);
    chk("s3_writes", log_addr.size(), 4);
    if (log_addr.size() == 4) begin
      chk("s3_a0", log_addr[0], DEPTH - 2);
      chk("s3_a1", log_addr[1], DEPTH - 1);
      chk("s3_a2", log_addr[2], 0);
      chk("s3_a3", log_addr[3], 1);
    end
    chk("s3_done", n_done, 1);

    // Gapped valid pattern 1,0,0,1,1 with three words
    clear_log();
    step(1, 0, 0, 0, 7, 3);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 2, 0, 0);
    step(0, 0, 0, 3, 0, 0);
    step(0, 0, 1, 4, 0, 0);
    step(0, 0, 1, 5, 0, 0);
    idle(2);
    chk("s4_writes", log_addr.size(), 3);
    if (log_data.size() == 3) chk("s4_last", log_data[2], 5);
    chk("s4_done", n_done, 1);

    // Zero-length frame finishes immediately
    clear_log();
    step(1, 0, 1, 9, 3, 0);
    chk("s5_done_now", int'(done), 1);
    chk("s5_wr_en", int'(wr_en), 0);
    idle(2);
    chk("s5_writes", log_addr.size(), 0);
    chk("s5_done", n_done, 1);

    // Oversized request clamps to the depth and flags len_err
    clear_log();
    step(1, 0, 0, 0, 3, DEPTH + 1);
    for (int i = 0; i < DEPTH + 4; i++) step(0, 0, 1, 64 + i, 0, 0);
    idle(1);
    chk("s6_len_err", int'(len_err), 1);
    chk("s6_writes", log_addr.size(), DEPTH);
    chk("s6_done", n_done, 1);
    chk("s6_cnt", int'(word_cnt), DEPTH);

    // Abort after two of five words; start while loading is ignored
    clear_log();
    step(1, 0, 0, 0, 0, 5);
    step(1, 0, 1, 1, 9, 2);
    step(0, 0, 1, 2, 0, 0);
    step(0, 1, 1, 3, 0, 0);
    chk("s7_idle", int'(busy), 0);
    idle(3);
    chk("s7_writes", log_addr.size(), 2);
    chk("s7_done", n_done, 0);
    chk("s7_cnt", int'(word_cnt), 2);

    // Randomized traffic checked cycle by cycle against the model
    for (int i = 0; i < 1500; i++) begin
      bit st, ab, v;
      int l;
      st = ($urandom_range(0, 5) == 0);
      ab = ($urandom_range(0, 39) == 0);
      v  = ($urandom_range(0, 9) < 7);
      l  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 2 * DEPTH + 1)
                                       : $urandom_range(0, 7);
      step(st, ab, v, int'($urandom_range(0, (1 << DW) - 1)),
           int'($urandom_range(0, DEPTH - 1)), l);
    end
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
